stage_mem: RTL and testbench

- Memory-access stage of the 5-stage pipeline, directly downstream of the execute stage.
- Owns the EX/MEM pipeline register. Issues load/store requests to the data-memory/MMIO bus over a req/ack handshake, with a timeout.
- Performs store byte-lane steering and load extract/extend, then drives the MEM/WB pipeline register.
- Supplies the EX/MEM forwarding taps and a pipeline stall to the hazard logic.

---
 rtl/stage_mem.sv | 186 ++++++++++++++++++
 tb/tb_stage_mem.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_mem.sv
// -----------------------------------------------------------------------------
// stage_mem : memory-access stage of the 5-stage pipeline.
//
// Owns the EX/MEM register, issues load/store transfers on a req/ack bus with
// a bounded wait, steers store byte lanes, extracts/extends load data and
// drives the MEM/WB register. Also exports EX/MEM forwarding taps and the
// pipeline stall.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   ex_*                       EX stage results (valid, ALU result/address,
//                              store data, rd, memory control, WB control)
//   mem_req/we/addr/wdata/wstrb  data bus request side
//   mem_rdata, mem_ack         data bus response side
//   stall_out                  freezes IF/ID/EX and the EX/MEM register
//   fw_data, fw_rd, fw_RegWrite  EX/MEM forwarding taps
//   wb_*                       MEM/WB register outputs
//   misalign_err, bus_err      single-cycle error pulses
// -----------------------------------------------------------------------------
module stage_mem #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [4:0]        ex_mem_ctrl,
    input  logic [1:0]        ex_wb_ctrl,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_out,
    output logic [DATA_W-1:0] fw_data,
    output logic [REG_W-1:0]  fw_rd,
    output logic              fw_RegWrite,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_rd,
    output logic              wb_RegWrite,
    output logic              wb_MemtoReg,
    output logic [DATA_W-1:0] wb_alu_data,
    output logic [DATA_W-1:0] wb_mem_data,
    output logic              misalign_err,
    output logic              bus_err
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    // funct3[1] selects word, else funct3[0] selects halfword, else byte;
    // funct3[2] selects zero extension for loads.
    function automatic logic [DATA_W-1:0] store_lanes(input logic [DATA_W-1:0] d,
                                                      input logic [2:0] f3);
        if (f3[1])      store_lanes = d;
        else if (f3[0]) store_lanes = {2{d[15:0]}};
        else            store_lanes = {4{d[7:0]}};
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] a, input logic [2:0] f3);
        if (f3[1])      store_strb = 4'b1111;
        else if (f3[0]) store_strb = a[1] ? 4'b1100 : 4'b0011;
        else            store_strb = 4'b0001 << a;
    endfunction

    function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] rd_data,
                                                       input logic [1:0] a,
                                                       input logic [2:0] f3);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = rd_data[{a, 3'b000} +: 8];
        h = a[1] ? rd_data[31:16] : rd_data[15:0];
        if (f3[1])      load_extract = rd_data;
        else if (f3[0]) load_extract = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
        else            load_extract = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
    endfunction

    logic              vld_p0;
    logic [DATA_W-1:0] alu_p0;
    logic [DATA_W-1:0] sdata_p0;
    logic [REG_W-1:0]  rd_p0;
    logic [4:0]        mctrl_p0;
    logic [1:0]        wbctrl_p0;

    logic [0:0] state, state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_cur;

    logic [2:0] f3;
    logic       is_load, is_store, mem_op, misaligned, go, timeout, retire;

    // ---- EX/MEM boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0    <= 1'b0;
            alu_p0    <= '0;
            sdata_p0  <= '0;
            rd_p0     <= '0;
            mctrl_p0  <= '0;
            wbctrl_p0 <= '0;
        end else if (!stall_out) begin
            vld_p0    <= ex_valid;
            alu_p0    <= ex_alu_result;
            sdata_p0  <= ex_store_data;
            rd_p0     <= ex_rd;
            mctrl_p0  <= ex_mem_ctrl;
            wbctrl_p0 <= ex_wb_ctrl;
        end
    end

    assign f3         = mctrl_p0[4:2];
    assign is_load    = mctrl_p0[0];
    assign is_store   = mctrl_p0[1];
    assign mem_op     = vld_p0 & (is_load | is_store);
    assign misaligned = f3[1] ? (|alu_p0[1:0]) : (f3[0] & alu_p0[0]);
    // The request is combinational from the held instruction, so a memory op
    // is on the bus in its very first MEM cycle (IDLE enters ACCESS at once).
    assign go         = mem_op & ~misaligned;
    assign cnt_cur    = (state == S_ACCESS) ? cnt : 8'd0;
    assign timeout    = go & ~mem_ack & (cnt_cur == TO_LAST);
    // The timeout cycle releases the stall so the aborted op drains as a bubble.
    assign stall_out  = go & ~mem_ack & ~timeout;
    assign retire     = vld_p0 & ~(mem_op & misaligned) & ~timeout;

    assign mem_req      = go;
    assign mem_we       = go & is_store;
    assign mem_addr     = go ? {alu_p0[DATA_W-1:2], 2'b00} : '0;
    assign mem_wdata    = (go & is_store) ? store_lanes(sdata_p0, f3) : '0;
    assign mem_wstrb    = (go & is_store) ? store_strb(alu_p0[1:0], f3) : 4'b0000;
    assign misalign_err = mem_op & misaligned;
    assign bus_err      = timeout;

    assign fw_data     = alu_p0;
    assign fw_rd       = rd_p0;
    assign fw_RegWrite = wbctrl_p0[0] & vld_p0;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (stall_out)  state_nxt = S_ACCESS;
            S_ACCESS: if (!stall_out) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= stall_out ? cnt_cur + 8'd1 : 8'd0;
        end
    end

    // ---- MEM/WB boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_RegWrite <= 1'b0;
            wb_MemtoReg <= 1'b0;
            wb_alu_data <= '0;
            wb_mem_data <= '0;
        end else if (stall_out) begin
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
        end else begin
            wb_valid    <= retire;
            wb_RegWrite <= retire & wbctrl_p0[0];
            wb_MemtoReg <= wbctrl_p0[1];
            wb_rd       <= rd_p0;
            wb_alu_data <= alu_p0;
            if (go & is_load & mem_ack)
                wb_mem_data <= load_extract(mem_rdata, alu_p0[1:0], f3);
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
module tb_stage_mem;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int TIMEOUT = 16;

    logic              clk;
    logic              rst_n;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_alu_result;
    logic [DATA_W-1:0] ex_store_data;
    logic [REG_W-1:0]  ex_rd;
    logic [4:0]        ex_mem_ctrl;
    logic [1:0]        ex_wb_ctrl;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              stall_out;
    logic [DATA_W-1:0] fw_data;
    logic [REG_W-1:0]  fw_rd;
    logic              fw_RegWrite;
    logic              wb_valid;
    logic [REG_W-1:0]  wb_rd;
    logic              wb_RegWrite;
    logic              wb_MemtoReg;
    logic [DATA_W-1:0] wb_alu_data;
    logic [DATA_W-1:0] wb_mem_data;
    logic              misalign_err;
    logic              bus_err;

    stage_mem #(.DATA_W(DATA_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_mem_ctrl(ex_mem_ctrl), .ex_wb_ctrl(ex_wb_ctrl),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_out(stall_out), .fw_data(fw_data), .fw_rd(fw_rd), .fw_RegWrite(fw_RegWrite),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite),
        .wb_MemtoReg(wb_MemtoReg), .wb_alu_data(wb_alu_data), .wb_mem_data(wb_mem_data),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        chk_mem;
        logic [31:0] alu;
        logic [31:0] mdat;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } bus_exp_t;

    localparam int E_MISALIGN = 1;
    localparam int E_BUSERR   = 2;

    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];
    int       err_q[$];
    wb_exp_t  mon_w;
    bus_exp_t mon_b;
    int       mon_e;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a bus completion,
    // a retired MEM/WB entry or an error pulse.
    always @(negedge clk) begin
        if (mem_req && mem_ack) begin
            if (bus_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL bus_unexpected actual_addr=0x%08h required=no transfer", mem_addr);
            end else begin
                mon_b = bus_q.pop_front();
                chk("bus_addr", mem_addr, mon_b.addr);
                chk1("bus_we", mem_we, mon_b.we);
                chk("bus_wstrb", 32'(mem_wstrb), 32'(mon_b.strb));
                if (mon_b.we) chk("bus_wdata", mem_wdata, mon_b.wdata);
            end
        end
        if (wb_valid) begin
            if (wb_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL wb_unexpected actual_rd=%0d required=no retire", wb_rd);
            end else begin
                mon_w = wb_q.pop_front();
                chk("wb_rd", 32'(wb_rd), 32'(mon_w.rd));
                chk1("wb_RegWrite", wb_RegWrite, mon_w.rw);
                chk1("wb_MemtoReg", wb_MemtoReg, mon_w.m2r);
                chk("wb_alu_data", wb_alu_data, mon_w.alu);
                if (mon_w.chk_mem) chk("wb_mem_data", wb_mem_data, mon_w.mdat);
            end
        end
        if (misalign_err || bus_err) begin
            if (err_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL err_unexpected actual_misalign=%b actual_bus=%b required=none",
                         misalign_err, bus_err);
            end else begin
                mon_e = err_q.pop_front();
                chk1("err_misalign", misalign_err, mon_e == E_MISALIGN);
                chk1("err_bus", bus_err, mon_e == E_BUSERR);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rd, input logic [4:0] mc, input logic [1:0] wc);
        ex_valid      = v;
        ex_alu_result = alu;
        ex_store_data = sd;
        ex_rd         = rd;
        ex_mem_ctrl   = mc;
        ex_wb_ctrl    = wc;
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic rw, input logic m2r,
                           input logic cm, input logic [31:0] alu, input logic [31:0] md);
        wb_exp_t w;
        w.rd = rd; w.rw = rw; w.m2r = m2r; w.chk_mem = cm; w.alu = alu; w.mdat = md;
        wb_q.push_back(w);
    endtask

    task automatic push_bus(input logic [31:0] addr, input logic we, input logic [3:0] strb,
                            input logic [31:0] wdata);
        bus_exp_t b;
        b.addr = addr; b.we = we; b.strb = strb; b.wdata = wdata;
        bus_q.push_back(b);
    endtask

    // Memory op acknowledged in its first MEM cycle.
    task automatic zero_wait(input logic [31:0] addr, input logic [31:0] sd,
                             input logic [31:0] rdata, input logic [4:0] rd,
                             input logic [4:0] mc, input logic [1:0] wc,
                             input logic [31:0] bus_addr, input logic [3:0] strb,
                             input logic [31:0] wdata, input logic [31:0] mdat);
        push_bus(bus_addr, mc[1], strb, wdata);
        push_wb(rd, wc[0], wc[1], mc[0], addr, mdat);
        drive(1'b1, addr, sd, rd, mc, wc);
        step();
        ex_valid  = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        #1;
        chk1("zw_req", mem_req, 1'b1);
        chk1("zw_stall", stall_out, 1'b0);
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 2'd0);

        #12;
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_stall", stall_out, 1'b0);
        chk1("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_alu", wb_alu_data, 32'h0);
        chk("rst_wb_mem", wb_mem_data, 32'h0);
        chk("rst_fw_data", fw_data, 32'h0);
        chk1("rst_misalign", misalign_err, 1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);
        #6 rst_n = 1'b1;
        step();

        // ALU op: forwarding one edge later, MEM/WB the edge after
        push_wb(5'd5, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0);
        drive(1'b1, 32'h1234, 32'h0, 5'd5, 5'b00000, 2'b01);
        step();
        ex_valid = 1'b0;
        chk("alu_fw_data", fw_data, 32'h1234);
        chk("alu_fw_rd", 32'(fw_rd), 32'd5);
        chk1("alu_fw_rw", fw_RegWrite, 1'b1);
        chk1("alu_stall", stall_out, 1'b0);
        chk1("alu_req", mem_req, 1'b0);
        step();
        chk1("alu_wb_valid", wb_valid, 1'b1);

        // LB at 0x103, ack after three stall cycles
        push_bus(32'h100, 1'b0, 4'b0000, 32'h0);
        push_wb(5'd7, 1'b1, 1'b1, 1'b1, 32'h103, 32'hFFFF_FF80);
        drive(1'b1, 32'h103, 32'h0, 5'd7, 5'b00001, 2'b11);
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk1("lb_stall", stall_out, 1'b1);
            chk1("lb_req", mem_req, 1'b1);
            chk("lb_addr", mem_addr, 32'h100);
            chk1("lb_fw_rw_held", fw_RegWrite, 1'b1);
            step();
            chk1("lb_bubble", wb_valid, 1'b0);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h80AB_CDEF;
        #1;
        chk1("lb_ack_stall", stall_out, 1'b0);
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        step();

        // SH at 0x2002, zero-wait
        zero_wait(32'h2002, 32'h0000_ABCD, 32'h0, 5'd0, 5'b00110, 2'b00,
                  32'h2000, 4'b1100, 32'hABCD_ABCD, 32'h0);
        // SB at 0x1
        zero_wait(32'h1, 32'h1234_5678, 32'h0, 5'd0, 5'b00010, 2'b00,
                  32'h0, 4'b0010, 32'h7878_7878, 32'h0);
        // SW at 0x44
        zero_wait(32'h44, 32'hCAFE_F00D, 32'h0, 5'd0, 5'b01010, 2'b00,
                  32'h44, 4'b1111, 32'hCAFE_F00D, 32'h0);
        // LH at 0x0 (sign extend)
        zero_wait(32'h0, 32'h0, 32'h1234_8001, 5'd12, 5'b00101, 2'b11,
                  32'h0, 4'b0000, 32'h0, 32'hFFFF_8001);
        // LBU at 0x2 (zero extend)
        zero_wait(32'h2, 32'h0, 32'h00C3_0000, 5'd13, 5'b10001, 2'b11,
                  32'h0, 4'b0000, 32'h0, 32'h0000_00C3);
        // LHU at 0x2
        zero_wait(32'h2, 32'h0, 32'hBEEF_1234, 5'd14, 5'b10101, 2'b11,
                  32'h0, 4'b0000, 32'h0, 32'h0000_BEEF);
        // LW at 0x8
        zero_wait(32'h8, 32'h0, 32'h8765_4321, 5'd15, 5'b01001, 2'b11,
                  32'h8, 4'b0000, 32'h0, 32'h8765_4321);
        step();

        // Misaligned LW at 0x6 and LHU at 0x5
        for (int k = 0; k < 2; k++) begin
            err_q.push_back(E_MISALIGN);
            if (k == 0) drive(1'b1, 32'h6, 32'h0, 5'd9, 5'b01001, 2'b11);
            else        drive(1'b1, 32'h5, 32'h0, 5'd9, 5'b10101, 2'b11);
            step();
            ex_valid = 1'b0;
            chk1("mis_req", mem_req, 1'b0);
            chk1("mis_stall", stall_out, 1'b0);
            chk1("mis_pulse", misalign_err, 1'b1);
            step();
            chk1("mis_pulse_end", misalign_err, 1'b0);
            chk1("mis_wb_valid", wb_valid, 1'b0);
            chk1("mis_wb_rw", wb_RegWrite, 1'b0);
        end

        // LW at 0x40 never acknowledged: 15 stall cycles, bus_err on the 16th
        err_q.push_back(E_BUSERR);
        drive(1'b1, 32'h40, 32'h0, 5'd10, 5'b01001, 2'b11);
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            chk1("to_stall", stall_out, 1'b1);
            chk1("to_bus_err_early", bus_err, 1'b0);
            step();
        end
        chk1("to_stall_release", stall_out, 1'b0);
        chk1("to_bus_err", bus_err, 1'b1);
        step();
        chk1("to_wb_valid", wb_valid, 1'b0);
        chk1("to_wb_rw", wb_RegWrite, 1'b0);
        chk1("to_req_after", mem_req, 1'b0);
        chk1("to_bus_err_end", bus_err, 1'b0);

        // Reset in the middle of an access
        drive(1'b1, 32'h80, 32'h0, 5'd3, 5'b01001, 2'b11);
        step();
        ex_valid = 1'b0;
        chk1("mid_req", mem_req, 1'b1);
        chk1("mid_stall", stall_out, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("mid_rst_req", mem_req, 1'b0);
        chk1("mid_rst_stall", stall_out, 1'b0);
        chk1("mid_rst_wb_valid", wb_valid, 1'b0);
        chk("mid_rst_wb_alu", wb_alu_data, 32'h0);
        chk("mid_rst_wb_rd", 32'(wb_rd), 32'h0);
        chk("mid_rst_fw_data", fw_data, 32'h0);
        #3 rst_n = 1'b1;
        step();
        chk1("post_rst_req", mem_req, 1'b0);
        chk1("post_rst_stall", stall_out, 1'b0);
        step();

        chk("wb_q_empty", 32'(wb_q.size()), 32'h0);
        chk("bus_q_empty", 32'(bus_q.size()), 32'h0);
        chk("err_q_empty", 32'(err_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
